mem_port_arbiter: RTL

- Shares the single L2/physical-memory port between the instruction-side and data-side miss ports of the LC-3b pipeline.
- Uses the same cyc/stb/we/ack handshake the data-memory stage drives toward dmem.
- Grants one requester at a time, with data priority and a bounded-starvation guarantee for instruction fetch.
- Keeps a conflict performance counter that software can read and clear.

---
 rtl/mem_port_arbiter.sv | 94 +++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one L2 port between I/D miss ports with data priority, bounded I starvation and a conflict counter
module mem_port_arbiter #(
    parameter int DATA_WIDTH   = 128,
    parameter int ADDR_WIDTH   = 16,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  imem_cyc,
    input  logic                  imem_stb,
    input  logic                  imem_we,
    input  logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_wdata,
    output logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  imem_ack,
    input  logic                  dmem_cyc,
    input  logic                  dmem_stb,
    input  logic                  dmem_we,
    input  logic [ADDR_WIDTH-1:0] dmem_addr,
    input  logic [DATA_WIDTH-1:0] dmem_wdata,
    output logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic                  dmem_ack,
    output logic                  l2_cyc,
    output logic                  l2_stb,
    output logic                  l2_we,
    output logic [ADDR_WIDTH-1:0] l2_addr,
    output logic [DATA_WIDTH-1:0] l2_wdata,
    input  logic [DATA_WIDTH-1:0] l2_rdata,
    input  logic                  l2_ack,
    input  logic                  perf_clear,
    output logic [15:0]           conflict_count,
    output logic                  busy
);
    localparam logic [1:0] IDLE = 2'd0, SERVE_I = 2'd1, SERVE_D = 2'd2, DRAIN = 2'd3;
    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] SMAX = SW'(MAX_D_STREAK);
    logic [1:0] state;
    logic [SW-1:0] streak;
    logic lat_we;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata, i_rd, d_rd;
    logic i_pend, d_pend, grant_i, grant_d, owner_cyc;
    always_comb begin
        i_pend     = imem_cyc & imem_stb;
        d_pend     = dmem_cyc & dmem_stb;
        grant_i    = (state == IDLE) & i_pend & (~d_pend | (streak == SMAX));
        grant_d    = (state == IDLE) & d_pend & ~grant_i;
        owner_cyc  = (state == SERVE_I) ? imem_cyc : dmem_cyc;
        busy       = state != IDLE;
        l2_cyc     = busy;
        l2_stb     = busy;
        l2_we      = busy & lat_we;
        l2_addr    = lat_addr;
        l2_wdata   = lat_wdata;
        imem_ack   = ~reset & l2_ack & (state == SERVE_I);
        dmem_ack   = ~reset & l2_ack & (state == SERVE_D);
        imem_rdata = imem_ack ? l2_rdata : i_rd;
        dmem_rdata = dmem_ack ? l2_rdata : d_rd;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            streak         <= '0;
            conflict_count <= '0;
            lat_we         <= 1'b0;
            lat_addr       <= '0;
            lat_wdata      <= '0;
            i_rd           <= '0;
            d_rd           <= '0;
        end else begin
            if (perf_clear)
                conflict_count <= '0;
            else if (i_pend && d_pend && conflict_count != 16'hFFFF)
                conflict_count <= conflict_count + 16'd1;
            if (imem_ack)
                i_rd <= l2_rdata;
            if (dmem_ack)
                d_rd <= l2_rdata;
            if (grant_i || grant_d) begin
                state     <= grant_i ? SERVE_I : SERVE_D;
                lat_we    <= grant_i ? imem_we : dmem_we;
                lat_addr  <= grant_i ? imem_addr : dmem_addr;
                lat_wdata <= grant_i ? imem_wdata : dmem_wdata;
            end else if (busy && l2_ack)
                state <= IDLE;
            else if (busy && state != DRAIN && !owner_cyc)
                state <= DRAIN;
            if (grant_i)
                streak <= '0;
            else if (grant_d && i_pend && streak != SMAX)
                streak <= streak + 1'b1;
        end
    end
endmodule
